// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiply-accumulate unit
// and its partial-product selector.
package booth_pkg;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_act_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // One Booth digit per pair of bits, plus one more for the extension bits.
    function automatic int booth_iters(input int w);
        return w / 2 + 1;
    endfunction

    function automatic pp_act_e booth_decode(input logic [2:0] grp);
        pp_act_e act;
        case (grp)
            3'b001, 3'b010: act = PP_POS1;
            3'b011:         act = PP_POS2;
            3'b100:         act = PP_NEG2;
            3'b101, 3'b110: act = PP_NEG1;
            default:        act = PP_ZERO;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier group and the
// (W+2)-bit extended multiplicand to a (W+3)-bit signed partial product.
module booth_pp_select
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   group,
    input  logic [W+1:0] mcand,
    output logic [W+2:0] pp
);

    localparam logic [W+1:0] ONE = 1;

    pp_act_e      act;
    logic [W+1:0] neg;

    assign act = booth_decode(group);

    // Negation on the extended width keeps -(-2^(W-1)) representable.
    assign neg = ~mcand + ONE;

    // The two extension bits guarantee bits W+1 and W agree, so the left
    // shift for the 2x cases never loses the sign.
    always_comb begin
        pp = '0;
        case (act)
            PP_POS1: pp = {mcand[W+1], mcand};
            PP_POS2: pp = {mcand, 1'b0};
            PP_NEG1: pp = {neg[W+1], neg};
            PP_NEG2: pp = {neg, 1'b0};
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mac.sv
// Iterative radix-4 Booth multiply-accumulate: product = addend + multiplicand * multiplier
// mod 2^(2W), one Booth digit retired per clock through a shared selector and adder.
module booth_r4_mac
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    input  logic [2*W-1:0] addend,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int N  = booth_iters(W);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST  = CW'(N - 1);
    localparam logic [CW-1:0] STEP  = CW'(1);

    state_e         state;
    logic [W+1:0]   mcand;
    logic [W+2:0]   mreg;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  iter;

    logic           accept;
    logic [W+1:0]   mcand_ext;
    logic [W+1:0]   mplier_ext;
    logic [W+2:0]   pp;
    logic [2*W-1:0] pp_ext;
    logic [2*W-1:0] pp_shift;
    logic [2*W-1:0] acc_next;

    assign accept = start && (state != S_RUN);

    assign mcand_ext  = signed_mode ? {{2{multiplicand[W-1]}}, multiplicand} : {2'b00, multiplicand};
    assign mplier_ext = signed_mode ? {{2{multiplier[W-1]}}, multiplier}     : {2'b00, multiplier};

    // mreg[2:0] is always the current group {2i+1, 2i, 2i-1}; bit 0 starts as the implicit zero.
    booth_pp_select #(.W(W)) u_sel (
        .group (mreg[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    assign pp_ext   = {{(W-3){pp[W+2]}}, pp};
    assign pp_shift = pp_ext << {iter, 1'b0};
    assign acc_next = acc + pp_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mreg    <= '0;
            acc     <= '0;
            iter    <= '0;
            product <= '0;
        end else if (accept) begin
            state <= S_RUN;
            mcand <= mcand_ext;
            mreg  <= {mplier_ext, 1'b0};
            acc   <= addend;
            iter  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    acc  <= acc_next;
                    mreg <= {2'b00, mreg[W+2:2]};
                    iter <= iter + STEP;
                    if (iter == LAST) begin
                        product <= acc_next;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_booth_r4_mac.sv
// Self-checking bench for booth_r4_mac: directed W=8 scenarios plus a W=16 random
// regression, with expected results queued at issue time and popped on done.
module tb_booth_r4_mac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] c8, p8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] c16, p16;

    booth_r4_mac #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8), .addend(c8),
        .busy(busy8), .done(done8), .product(p8)
    );

    booth_r4_mac #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16), .addend(c16),
        .busy(busy16), .done(done16), .product(p16)
    );

    logic [15:0] q8[$];
    logic [31:0] q16[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        logic [15:0] r;
    } vec_t;

    // Plain integer reference: c + a*b reduced mod 2^(2w).
    function automatic logic [31:0] model(input int w, input bit sm, input logic [15:0] a,
                                          input logic [15:0] b, input logic [31:0] c);
        longint av, bv, r, mask;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        r = (longint'(c) + av * bv) & mask;
        return r[31:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        logic [31:0] e;
        e = model(8, sm, {8'h00, a}, {8'h00, b}, {16'h0000, c});
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b; c8 = c;
        q8.push_back(e[15:0]);
        @(negedge clk);
        start8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 16'($urandom);
    endtask

    task automatic issue16(input bit sm, input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
        start16 = 1'b1; sm16 = sm; a16 = a; b16 = b; c16 = c;
        q16.push_back(model(16, sm, a, b, c));
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); c16 = $urandom;
    endtask

    // lat counts rising edges since the accepting edge; busy must hold until done.
    task automatic wait8(output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (!done8 && lat < 20) begin
            if (!busy8) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!done16 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0; c8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0; c16 = 0;
        @(negedge clk);
        n_checks++;
        if ({busy8, done8, p8} !== 18'h0) begin
            n_fail++; $display("FAIL reset_w8: busy=%b done=%b product=%h, want 0 0 0000", busy8, done8, p8);
        end
        n_checks++;
        if ({busy16, done16, p16} !== 34'h0) begin
            n_fail++; $display("FAIL reset_w16: busy=%b done=%b product=%h, want 0 0 0", busy16, done16, p16);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_signed_basic();
        int lat; bit bok; logic [15:0] e;
        issue8(1'b1, 8'hFD, 8'd5, 16'h0000);
        wait8(lat, bok);
        e = q8.pop_front();
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL signed_latency: got %0d cycles, want 5", lat); end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL signed_busy: busy dropped before done, want high cycles 1-5"); end
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL signed_busy_done: busy=%b in done cycle, want 0", busy8); end
        n_checks++;
        if (p8 !== e || p8 !== 16'hFFF1) begin
            n_fail++; $display("FAIL signed_product: got %h, want %h (FFF1)", p8, e);
        end
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: done=%b after one cycle, want 0", done8); end
    endtask

    task automatic test_corners();
        vec_t vt[5];
        int lat; bit bok; logic [15:0] e;
        vt[0] = '{1'b0, 8'hFF, 8'hFF, 16'h0000, 16'hFE01};
        vt[1] = '{1'b1, 8'h80, 8'h80, 16'h0000, 16'h4000};
        vt[2] = '{1'b1, 8'h80, 8'h7F, 16'h0000, 16'hC080};
        vt[3] = '{1'b0, 8'd7,  8'd6,  16'd100,  16'h008E};
        vt[4] = '{1'b0, 8'hFF, 8'hFF, 16'h2000, 16'h1E01};
        foreach (vt[k]) begin
            issue8(vt[k].sm, vt[k].a, vt[k].b, vt[k].c);
            wait8(lat, bok);
            e = q8.pop_front();
            n_checks++;
            if (lat !== 5) begin n_fail++; $display("FAIL corner%0d_latency: got %0d, want 5", k, lat); end
            n_checks++;
            if (p8 !== e || p8 !== vt[k].r) begin
                n_fail++; $display("FAIL corner%0d_product: got %h, want %h", k, p8, vt[k].r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_midrun();
        int lat; bit bok, extra; logic [15:0] e;
        issue8(1'b0, 8'd12, 8'd11, 16'd5);
        @(negedge clk); @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'd99; b8 = 8'd99; c8 = 16'h1234;
        @(negedge clk);
        start8 = 1'b0;
        wait8(lat, bok);
        e = q8.pop_front();
        n_checks++;
        if (lat + 3 !== 5) begin n_fail++; $display("FAIL midrun_latency: got %0d, want 5", lat + 3); end
        n_checks++;
        if (p8 !== e) begin n_fail++; $display("FAIL midrun_product: got %h, want %h", p8, e); end
        extra = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done8) extra = 1'b1;
        end
        n_checks++;
        if (extra) begin n_fail++; $display("FAIL midrun_queued: got an extra done pulse, want none"); end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; logic [15:0] ea, eb;
        issue8(1'b1, 8'hF0, 8'd9, 16'h0100);
        wait8(lat, bok);
        ea = q8.pop_front();
        n_checks++;
        if (p8 !== ea) begin n_fail++; $display("FAIL b2b_first: got %h, want %h", p8, ea); end
        issue8(1'b0, 8'd200, 8'd3, 16'h0001);
        n_checks++;
        if (p8 !== ea) begin n_fail++; $display("FAIL b2b_hold: product %h changed during run, want %h", p8, ea); end
        wait8(lat, bok);
        eb = q8.pop_front();
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d, want 5", lat); end
        n_checks++;
        if (p8 !== eb) begin n_fail++; $display("FAIL b2b_second: got %h, want %h", p8, eb); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat; bit bok, seen; logic [15:0] e;
        issue8(1'b1, 8'd50, 8'd3, 16'h0000);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, p8} !== 18'h0) begin
            n_fail++; $display("FAIL abort_reset: busy=%b done=%b product=%h, want 0 0 0000", busy8, done8, p8);
        end
        void'(q8.pop_front());
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_nodone: activity after aborted op, want none"); end
        issue8(1'b0, 8'd9, 8'd9, 16'h0000);
        wait8(lat, bok);
        e = q8.pop_front();
        n_checks++;
        if (lat !== 5 || p8 !== e || p8 !== 16'd81) begin
            n_fail++; $display("FAIL abort_next: got %h after %0d cycles, want 0051 after 5", p8, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_w16_random();
        int lat; logic [31:0] e; logic [15:0] a, b;
        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (k % 50 == 0) a = 16'h8000;
            if (k % 50 == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
            issue16(1'($urandom_range(0, 1)), a, b, $urandom);
            wait16(lat);
            e = q16.pop_front();
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL w16_latency[%0d]: got %0d, want 9", k, lat); end
            n_checks++;
            if (p16 !== e) begin n_fail++; $display("FAIL w16_product[%0d]: got %h, want %h", k, p16, e); end
            if (k % 3 == 0) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed_basic();
        test_corners();
        test_ignore_midrun();
        test_back_to_back();
        test_abort();
        test_w16_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
